ir_enc: RTL and testbench
=========================

Name: ir_enc

Overview:
- Pipelined RV32I instruction encoder; inverse of the pipeline's field decoder. Packs opcode, funct3, funct7, register indices and a full 32-bit immediate into a 32-bit instruction word.
- Used by the self-checking instruction generator and the memory-image loader on the pipeline's test side.
- Valid/ready on both sides. Immediate range check per format. Output FIFO absorbs downstream backpressure.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the encoded-word and error counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request fields valid.
- in_ready  out  1  encoder accepts the request this cycle.
- in_opcode  in  7  rv32i_opcode.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7; used by op_reg and by op_imm shifts only.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  immediate, sign-extended value as the decoder would produce it.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_word  out  32  encoded instruction at the FIFO head.
- out_err  out  1  head entry failed the range check.
- enc_count  out  CNT_W  words written into the FIFO; saturating.
- err_count  out  CNT_W  error words written into the FIFO; saturating.

Behaviour:
- Reset: rst high at an edge clears the S1 valid bit, FIFO pointers and both counters. out_valid=0, in_ready=1 from the next cycle. out_word and out_err are don't-care while out_valid=0. Reset overrides any concurrent handshake, including mid-stream; in-flight data is dropped.
- Pipeline: input handshake -> S1 register -> FIFO. S1 holds the encoded word and the error bit.
- s1_adv = s1_valid & (fifo not full | (out_valid & out_ready)).
- in_ready = !s1_valid | s1_adv. This is a combinational path from out_ready; that path is intentional.
- Latency: a request accepted at edge N appears at out_word after edge N+1 when the FIFO is empty. Full throughput is one word per cycle.
- Simultaneous FIFO push and pop while full is allowed; occupancy stays unchanged.
- FIFO order is strict. Pointers wrap modulo FIFO_DEPTH, with an extra wrap bit for full/empty detection.
- R-type (op_reg): {funct7, rs2, rs1, funct3, rd, opcode}. in_imm is ignored. Never errors.
- I-type (op_load, op_jalr, op_imm non-shift, op_csr):
  - Word is {imm[11:0], rs1, funct3, rd, opcode}.
  - Error unless imm[31:11] are all equal.
- op_imm shifts (funct3 001 or 101):
  - Word is {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - Error unless imm[31:5]==0.
- S-type (op_store):
  - Word is {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - Error unless imm[31:11] are all equal.
- B-type (op_br):
  - Word is {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - Error unless imm[31:12] are all equal and imm[0]==0.
- U-type (op_lui, op_auipc):
  - Word is {imm[31:12], rd, opcode}.
  - Error unless imm[11:0]==0.
- J-type (op_jal):
  - Word is {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Error unless imm[31:20] are all equal and imm[0]==0.
- Unlisted opcode: error.
- On error the word is replaced by 32'h0000_0013 (addi x0,x0,0) and err=1. The entry is still pushed, so ordering is preserved.
- Counters: enc_count increments on every FIFO push. err_count increments on every push with err=1. Both stop at all-ones.

Decomposition:
- rv32i_types already holds rv32i_opcode. Add to it:
  - an enum rv32i_format {fmt_r, fmt_i, fmt_shift, fmt_s, fmt_b, fmt_u, fmt_j, fmt_bad};
  - the constant NOP_WORD = 32'h0000_0013.
- Format selection and range check form one combinational function inside ir_enc.
- One sub-module: ir_enc_fifo, a parameterised synchronous FIFO with push/pop/full/empty and the same clk/rst.

Test Plan:
- Reset then addi x1,x2,-1 (op_imm, f3=000, rd=1, rs1=2, imm=FFFFFFFF) -> out_word=0xFFF10093 after one edge, out_err=0, enc_count=1.
- beq x1,x2,+8 (op_br, rs1=1, rs2=2, imm=8) -> 0x00208463. jal x1,+2048 -> 0x001000EF. lui x5 imm=0x12345000 -> 0x123452B7.
- Range errors:
  - addi imm=0x800 -> out_word=0x00000013, out_err=1, err_count=1.
  - beq imm=3 (odd) -> error.
  - lui imm=0x12345001 -> error.
- Backpressure, FIFO_DEPTH=4, out_ready=0, stream 6 requests -> 5 accepted and in_ready=0. Then out_ready=1 -> 5 words in order at one per cycle, then 6th accepted.
- Full FIFO with out_ready=1 and in_valid=1 continuously -> no bubbles, occupancy constant, counters advance by 1 per cycle.
- rst asserted with 3 entries queued -> out_valid=0 next cycle, both counts 0, first request after reset returns correct word.
- Round-trip: random legal fields -> feed out_word through the pipeline's field decoder. rd, rs1, rs2, funct3 and the format's imm must equal the inputs for 10k words.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I encoding types: opcodes, instruction formats and the encoder's
// pipeline payload.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    fmt_r, fmt_i, fmt_shift, fmt_s, fmt_b, fmt_u, fmt_j, fmt_bad
  } rv32i_format;

  // addi x0,x0,0 stands in for any request that fails its range check
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } enc_t;

endpackage

// File: rtl/ir_enc_fifo.sv
// Synchronous FIFO with wrap-bit pointers; storage is left unreset, only the
// pointers clear.
module ir_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // A push while full is only issued alongside a pop, so the slot being
  // overwritten is the head that is leaving this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ir_enc.sv
// RV32I instruction encoder: one register stage of packing and range checking
// followed by an output FIFO that absorbs downstream backpressure.
module ir_enc import rv32i_types::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic enc_t encode(
    input logic [6:0]  opc,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    rv32i_format fmt;
    enc_t        r;
    logic        ok;
    case (opc)
      op_reg:                    fmt = fmt_r;
      op_load, op_jalr, op_csr:  fmt = fmt_i;
      op_imm:                    fmt = (f3 == 3'b001 || f3 == 3'b101) ? fmt_shift : fmt_i;
      op_store:                  fmt = fmt_s;
      op_br:                     fmt = fmt_b;
      op_lui, op_auipc:          fmt = fmt_u;
      op_jal:                    fmt = fmt_j;
      default:                   fmt = fmt_bad;
    endcase
    r.word = NOP_WORD;
    ok     = 1'b0;
    case (fmt)
      fmt_r: begin
        r.word = {f7, rs2, rs1, f3, rd, opc};
        ok     = 1'b1;
      end
      fmt_i: begin
        r.word = {imm[11:0], rs1, f3, rd, opc};
        ok     = (&imm[31:11]) | ~(|imm[31:11]);
      end
      fmt_shift: begin
        r.word = {f7, imm[4:0], rs1, f3, rd, opc};
        ok     = ~(|imm[31:5]);
      end
      fmt_s: begin
        r.word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
        ok     = (&imm[31:11]) | ~(|imm[31:11]);
      end
      fmt_b: begin
        r.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
        ok     = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      end
      fmt_u: begin
        r.word = {imm[31:12], rd, opc};
        ok     = ~(|imm[11:0]);
      end
      fmt_j: begin
        r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
        ok     = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      end
      default: ok = 1'b0;
    endcase
    if (!ok) r.word = NOP_WORD;
    r.err = ~ok;
    return r;
  endfunction

  enc_t enc_p0;
  enc_t enc_p1;
  enc_t head;
  logic vld_p1;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic s1_adv;

  assign enc_p0 = encode(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign s1_adv    = vld_p1 & (~fifo_full | pop);
  assign in_ready  = ~vld_p1 | s1_adv;

  // ---- stage p0 -> p1: capture encoded word and error flag ----
  always_ff @(posedge clk) begin
    if (rst)           vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) enc_p1 <= enc_p0;
  end

  // ---- stage p1 -> FIFO ----
  ir_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(enc_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_adv),
    .pop   (pop),
    .wdata (enc_p1),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_word = head.word;
  assign out_err  = head.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (s1_adv) begin
      enc_count <= sat_inc(enc_count);
      if (enc_p1.err) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_ir_enc.sv
// Scoreboard bench for ir_enc: directed vectors, backpressure, throughput,
// mid-stream reset and a long randomized run with decoder round-trip.
module tb_ir_enc;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_word;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  ir_enc #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
  } req_t;

  req_t sbq[$];
  req_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   n_err = 0;
  bit   rnd_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
    req_t r;
    r.op = op; r.f3 = f3; r.f7 = f7; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    r.word = 32'h0; r.err = 1'b0;
    return r;
  endfunction

  // Reference: legality from numeric ranges, word from shifted field values.
  function automatic req_t model(input req_t r);
    longint      s;
    longint      u;
    bit          ok;
    logic [31:0] w;
    logic [31:0] rd_s, rs1_s, rs2_s, f3_s, op_v;
    s = longint'($signed(r.imm));
    u = longint'(r.imm);
    rd_s = 32'(r.rd) << 7;  rs1_s = 32'(r.rs1) << 15; rs2_s = 32'(r.rs2) << 20;
    f3_s = 32'(r.f3) << 12; op_v = 32'(r.op);
    ok = 0; w = 32'h0;
    case (r.op)
      OP_REG: begin
        ok = 1;
        w = (32'(r.f7) << 25) | rs2_s | rs1_s | f3_s | rd_s | op_v;
      end
      OP_LOAD, OP_JALR, OP_CSR, OP_IMM: begin
        if (r.op == OP_IMM && (r.f3 == 3'd1 || r.f3 == 3'd5)) begin
          ok = (u < 32);
          w = (32'(r.f7) << 25) | ((r.imm & 32'd31) << 20) | rs1_s | f3_s | rd_s | op_v;
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w = ((r.imm & 32'hFFF) << 20) | rs1_s | f3_s | rd_s | op_v;
        end
      end
      OP_STORE: begin
        ok = (s >= -2048) && (s <= 2047);
        w = (((r.imm >> 5) & 32'd127) << 25) | rs2_s | rs1_s | f3_s | ((r.imm & 32'd31) << 7) | op_v;
      end
      OP_BR: begin
        ok = (s >= -4096) && (s <= 4094) && ((r.imm & 32'd1) == 0);
        w = (((r.imm >> 12) & 32'd1) << 31) | (((r.imm >> 5) & 32'd63) << 25) | rs2_s | rs1_s | f3_s
          | (((r.imm >> 1) & 32'd15) << 8) | (((r.imm >> 11) & 32'd1) << 7) | op_v;
      end
      OP_LUI, OP_AUIPC: begin
        ok = ((r.imm % 4096) == 0);
        w = (r.imm & 32'hFFFFF000) | rd_s | op_v;
      end
      OP_JAL: begin
        ok = (s >= -1048576) && (s <= 1048574) && ((r.imm & 32'd1) == 0);
        w = (((r.imm >> 20) & 32'd1) << 31) | (((r.imm >> 1) & 32'd1023) << 21)
          | (((r.imm >> 11) & 32'd1) << 20) | (((r.imm >> 12) & 32'd255) << 12) | rd_s | op_v;
      end
      default: ok = 0;
    endcase
    r.err  = !ok;
    r.word = ok ? w : 32'h0000_0013;
    return r;
  endfunction

  // Field decoder as the pipeline would apply it; returns 1 when fields survive.
  function automatic bit roundtrip(input req_t r, input logic [31:0] w);
    logic [31:0] imm;
    bit ok;
    ok = (w[6:0] == r.op);
    case (w[6:0])
      OP_REG: ok &= (w[11:7] == r.rd) && (w[19:15] == r.rs1) && (w[24:20] == r.rs2)
                    && (w[14:12] == r.f3) && (w[31:25] == r.f7);
      OP_LOAD, OP_JALR, OP_CSR, OP_IMM: begin
        if (w[6:0] == OP_IMM && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) begin
          imm = {27'b0, w[24:20]};
          ok &= (w[31:25] == r.f7);
        end else begin
          imm = {{20{w[31]}}, w[31:20]};
        end
        ok &= (w[11:7] == r.rd) && (w[19:15] == r.rs1) && (w[14:12] == r.f3) && (imm == r.imm);
      end
      OP_STORE: begin
        imm = {{20{w[31]}}, w[31:25], w[11:7]};
        ok &= (w[19:15] == r.rs1) && (w[24:20] == r.rs2) && (w[14:12] == r.f3) && (imm == r.imm);
      end
      OP_BR: begin
        imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        ok &= (w[19:15] == r.rs1) && (w[24:20] == r.rs2) && (w[14:12] == r.f3) && (imm == r.imm);
      end
      OP_LUI, OP_AUIPC: begin
        imm = {w[31:12], 12'b0};
        ok &= (w[11:7] == r.rd) && (imm == r.imm);
      end
      OP_JAL: begin
        imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        ok &= (w[11:7] == r.rd) && (imm == r.imm);
      end
      default: ok = 0;
    endcase
    return ok;
  endfunction

  function automatic req_t rand_req(input bit legal);
    logic [6:0]  ops [10] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
                              OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_CSR};
    logic [31:0] x;
    req_t r;
    r = mk(ops[$urandom_range(9)], 3'($urandom), 7'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), $urandom);
    x = $urandom;
    if (!legal) begin
      if ($urandom_range(3) == 0) r.op = 7'($urandom);
    end else begin
      case (r.op)
        OP_LOAD, OP_JALR, OP_CSR, OP_IMM, OP_STORE: begin
          if (r.op == OP_IMM && (r.f3 == 3'd1 || r.f3 == 3'd5)) r.imm = 32'($urandom_range(31));
          else r.imm = {{20{x[11]}}, x[11:0]};
        end
        OP_BR:            r.imm = {{19{x[12]}}, x[12:1], 1'b0};
        OP_LUI, OP_AUIPC: r.imm = {x[31:12], 12'b0};
        OP_JAL:           r.imm = {{11{x[20]}}, x[20:1], 1'b0};
        default: ;
      endcase
    end
    return model(r);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 64'(out_word), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_word", 64'(out_word), 64'(mon_e.word));
        chk("out_err", 64'(out_err), 64'(mon_e.err));
        if (!mon_e.err) chk("roundtrip", 64'(roundtrip(mon_e, out_word)), 64'd1);
      end
    end
  end

  task automatic push_exp(input req_t r);
    sbq.push_back(r);
    n_acc++;
    if (r.err) n_err++;
  endtask

  task automatic drive(input req_t r);
    in_opcode = r.op; in_funct3 = r.f3; in_funct7 = r.f7;
    in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2; in_imm = r.imm;
    in_valid = 1'b1;
  endtask

  task automatic accept(input req_t r, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(r);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input req_t r);
    drive(r);
    accept(r, 60);
  endtask

  task automatic send_const(input req_t r, input logic [31:0] w, input logic e);
    r.word = w; r.err = e;
    send(r);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!out_valid && sbq.size() == 0) done = 1;
    end
    chk("drain_done", 64'(done), 64'd1);
    chk("enc_count", 64'(enc_count), 64'(n_acc));
    chk("err_count", 64'(err_count), 64'(n_err));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    logic [CNT_W-1:0] prev_cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_enc_count", 64'(enc_count), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    @(posedge clk); #1;

    // First word latency: visible after the edge following acceptance.
    out_ready = 1'b1;
    send_const(mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF), 32'hFFF1_0093, 1'b0);
    @(negedge clk);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_enc_count", 64'(enc_count), 64'd1);
    @(posedge clk); #1;

    send_const(mk(OP_BR, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8), 32'h0020_8463, 1'b0);
    send_const(mk(OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048), 32'h0010_00EF, 1'b0);
    send_const(mk(OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000), 32'h1234_52B7, 1'b0);
    send_const(mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0800), 32'h0000_0013, 1'b1);
    send_const(mk(OP_BR, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3), 32'h0000_0013, 1'b1);
    send_const(mk(OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001), 32'h0000_0013, 1'b1);
    send(model(mk(OP_IMM, 3'd0, 7'd0, 5'd3, 5'd4, 5'd0, 32'hFFFF_F800)));
    send(model(mk(OP_IMM, 3'd0, 7'd0, 5'd3, 5'd4, 5'd0, 32'h0000_07FF)));
    send(model(mk(OP_IMM, 3'd1, 7'd0, 5'd3, 5'd4, 5'd0, 32'd31)));
    send(model(mk(OP_IMM, 3'd5, 7'h20, 5'd3, 5'd4, 5'd0, 32'd32)));
    send(model(mk(OP_JAL, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'hFFF0_0000)));
    send(model(mk(OP_JAL, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h0010_0000)));
    send(model(mk(OP_BR, 3'd1, 7'd0, 5'd0, 5'd3, 5'd4, 32'd4094)));
    send(model(mk(OP_BR, 3'd1, 7'd0, 5'd0, 5'd3, 5'd4, 32'd4096)));
    send(model(mk(7'b1111111, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0)));
    drain();

    // Backpressure: S1 plus a full FIFO hold five requests.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(rand_req(1));
    r = rand_req(1);
    drive(r);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    accept(r, 4);
    drain();

    // Throughput with a full FIFO: one in, one out, every cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(rand_req(1));
    out_ready = 1'b1;
    prev_cnt = '0;
    for (int i = 0; i < 20; i++) begin
      r = rand_req($urandom_range(3) != 0);
      drive(r);
      @(negedge clk);
      chk("tp_in_ready", 64'(in_ready), 64'd1);
      chk("tp_out_valid", 64'(out_valid), 64'd1);
      if (i > 0) chk("tp_enc_step", 64'(enc_count), 64'(prev_cnt + CNT_W'(1)));
      prev_cnt = enc_count;
      push_exp(r);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset with entries queued drops everything in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_req(1));
    @(posedge clk); #1;
    rst = 1'b1;
    sbq.delete();
    n_acc = 0; n_err = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_enc_count", 64'(enc_count), 64'd0);
    chk("mid_rst_err_count", 64'(err_count), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_const(mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF), 32'hFFF1_0093, 1'b0);
    drain();

    // Randomized run with random gaps and random backpressure.
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(3) != 0);
        end
      end
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
          end
          send(rand_req($urandom_range(9) != 0));
        end
        rnd_done = 1;
      end
    join
    drain();
    chk("final_queue_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
